// File: rtl/multicore_busarbiter.sv
// Round-robin time-slice arbiter: one downstream bus shared by NCORES cores.
// Define ARB_SKIP_IDLE_EN so rotation skips cores with no pending request.
module multicore_busarbiter #(
  parameter  int NCORES  = 4,
  parameter  int AW      = 32,
  parameter  int DW      = 32,
  parameter  int QUANTUM = 10,
  localparam int GW      = $clog2(NCORES)
) (
  input  logic                 CLK,
  input  logic                 RST_X,
  input  logic                 init_done,
  input  logic [NCORES-1:0]    core_req,
  input  logic [NCORES-1:0]    core_bnd,
  input  logic [NCORES*AW-1:0] core_addr,
  input  logic [NCORES*DW-1:0] core_wdata,
  input  logic [NCORES-1:0]    core_we,
  input  logic [NCORES-1:0]    core_le,
  output logic [NCORES*DW-1:0] core_rdata,
  output logic [NCORES-1:0]    core_busy,
  output logic [AW-1:0]        s_addr,
  output logic [DW-1:0]        s_wdata,
  output logic                 s_we,
  output logic                 s_le,
  input  logic [DW-1:0]        s_rdata,
  input  logic                 s_busy,
  output logic [GW-1:0]        grant,
  output logic [NCORES-1:0]    grant_oh
);

  typedef enum logic [1:0] {S_RUN, S_WAIT_BND, S_SWITCH, S_SETTLE} state_e;

  localparam int            CW       = 8;
  localparam int            GW1      = GW + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(QUANTUM - 1);

  state_e            state_q;
  logic [CW-1:0]     cnt_q;
  logic [GW-1:0]     grant_q;
  logic [GW-1:0]     target_q;
  logic [NCORES-1:0] grant_oh_q;
  logic [GW-1:0]     next_d;
  logic              handover;

`ifdef ARB_SKIP_IDLE_EN
  // First requesting core after the owner in cyclic order; the owner itself if none.
  always_comb begin
    logic [GW1-1:0] cand;
    logic           found;
    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    next_d = grant_q;
    cand   = '0;
    found  = 1'b0;
    for (int k = 1; k < NCORES; k++) begin
      cand = {1'b0, grant_q} + GW1'(k);
      if (cand >= GW1'(NCORES)) cand = cand - GW1'(NCORES);
      if (!found && core_req[cand[GW-1:0]]) begin
        next_d = cand[GW-1:0];
        found  = 1'b1;
      end
    end
  end
`else
  // Wrap by compare so non-power-of-two core counts never reach an invalid index.
  assign next_d = (grant_q == GW'(NCORES - 1)) ? '0 : grant_q + GW'(1);

  logic unused_req;
  assign unused_req = ^core_req;
`endif

  always_ff @(posedge CLK) begin
    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    if (!RST_X) begin
      state_q    <= S_RUN;
      cnt_q      <= '0;
      grant_q    <= '0;
      target_q   <= '0;
      grant_oh_q <= NCORES'(1);
    end else if (init_done) begin
      case (state_q)
        S_RUN: begin
          if (cnt_q == CNT_LAST) state_q <= S_WAIT_BND;
          else                   cnt_q   <= cnt_q + CW'(1);
        end
        S_WAIT_BND: begin
          if (core_bnd[grant_q] && !s_busy) begin
            if (next_d != grant_q) begin
              target_q <= next_d;
              state_q  <= S_SWITCH;
            end else begin
              state_q <= S_RUN;
              cnt_q   <= '0;
            end
          end
        end
        S_SWITCH: begin
          grant_q    <= target_q;
          grant_oh_q <= NCORES'(1) << target_q;
          state_q    <= S_SETTLE;
        end
        default: begin
          state_q <= S_RUN;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Both sides of a hand-over are stalled so nobody samples a half-switched bus.
  assign handover = (state_q == S_SWITCH) || (state_q == S_SETTLE);

  logic [AW-1:0] addr_arr  [NCORES];
  logic [DW-1:0] wdata_arr [NCORES];

  for (genvar i = 0; i < NCORES; i++) begin : g_core
    assign addr_arr[i]             = core_addr[i*AW +: AW];
    assign wdata_arr[i]            = core_wdata[i*DW +: DW];
    assign core_rdata[i*DW +: DW]  = grant_oh_q[i] ? s_rdata : '0;
    assign core_busy[i]            = ~grant_oh_q[i] | handover | s_busy;
  end

  assign s_addr   = addr_arr[grant_q];
  assign s_wdata  = wdata_arr[grant_q];
  assign s_we     = core_we[grant_q];
  assign s_le     = core_le[grant_q];
  assign grant    = grant_q;
  assign grant_oh = grant_oh_q;

endmodule

// File: tb/tb_multicore_busarbiter.sv
// Self-checking bench for multicore_busarbiter: vector table, directed corner
// sequences and a randomized run against a slice/hand-over reference model.
module tb_multicore_busarbiter;

  localparam int NC = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int Q  = 10;

  localparam int PH_RUN    = 0;
  localparam int PH_WAIT   = 1;
  localparam int PH_SWITCH = 2;
  localparam int PH_SETTLE = 3;

  logic             CLK;
  logic             RST_X;
  logic             init_done;
  logic [NC-1:0]    core_req;
  logic [NC-1:0]    core_bnd;
  logic [NC*AW-1:0] core_addr;
  logic [NC*DW-1:0] core_wdata;
  logic [NC-1:0]    core_we;
  logic [NC-1:0]    core_le;
  logic [NC*DW-1:0] core_rdata;
  logic [NC-1:0]    core_busy;
  logic [AW-1:0]    s_addr;
  logic [DW-1:0]    s_wdata;
  logic             s_we;
  logic             s_le;
  logic [DW-1:0]    s_rdata;
  logic             s_busy;
  logic [1:0]       grant;
  logic [NC-1:0]    grant_oh;

  logic [3*DW-1:0]  rdata3;
  logic [2:0]       busy3;
  logic [AW-1:0]    s_addr3;
  logic [DW-1:0]    s_wdata3;
  logic             s_we3;
  logic             s_le3;
  logic [1:0]       grant3;
  logic [2:0]       grant_oh3;

  int checks = 0;
  int errors = 0;

  // Reference model: owner, hand-over phase, RUN cycles left, pending target.
  int m_grant  = 0;
  int m_phase  = PH_RUN;
  int m_left   = Q;
  int m_target = 0;

  multicore_busarbiter #(.NCORES(NC), .AW(AW), .DW(DW), .QUANTUM(Q)) dut (
    .CLK(CLK), .RST_X(RST_X), .init_done(init_done),
    .core_req(core_req), .core_bnd(core_bnd), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_we(core_we), .core_le(core_le),
    .core_rdata(core_rdata), .core_busy(core_busy),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_we(s_we), .s_le(s_le),
    .s_rdata(s_rdata), .s_busy(s_busy), .grant(grant), .grant_oh(grant_oh)
  );

  multicore_busarbiter #(.NCORES(3), .AW(AW), .DW(DW), .QUANTUM(2)) dut3 (
    .CLK(CLK), .RST_X(RST_X), .init_done(1'b1),
    .core_req(3'b111), .core_bnd(3'b111), .core_addr('0),
    .core_wdata('0), .core_we(3'b000), .core_le(3'b000),
    .core_rdata(rdata3), .core_busy(busy3),
    .s_addr(s_addr3), .s_wdata(s_wdata3), .s_we(s_we3), .s_le(s_le3),
    .s_rdata(32'h0), .s_busy(1'b0), .grant(grant3), .grant_oh(grant_oh3)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int model_next(input int g, input logic [NC-1:0] req);
`ifdef ARB_SKIP_IDLE_EN
    for (int k = 1; k < NC; k++)
      if (((req >> ((g + k) % NC)) & 4'd1) != 4'd0) return (g + k) % NC;
    return g;
`else
    if (req == '1) return (g + 1) % NC;
    return (g + 1) % NC;
`endif
  endfunction

  task automatic model_step();
    if (!RST_X) begin
      m_grant = 0; m_phase = PH_RUN; m_left = Q;
    end else if (init_done) begin
      case (m_phase)
        PH_RUN: begin
          m_left--;
          if (m_left == 0) m_phase = PH_WAIT;
        end
        PH_WAIT: begin
          if (((core_bnd >> m_grant) & 4'd1) != 4'd0 && !s_busy) begin
            m_target = model_next(m_grant, core_req);
            if (m_target != m_grant) m_phase = PH_SWITCH;
            else begin m_phase = PH_RUN; m_left = Q; end
          end
        end
        PH_SWITCH: begin m_grant = m_target; m_phase = PH_SETTLE; end
        default:   begin m_phase = PH_RUN; m_left = Q; end
      endcase
    end
  endtask

  // One clock: model follows the inputs the DUT sampled, then return at negedge.
  task automatic tick();
    @(posedge CLK);
    model_step();
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RST_X = 1'b0;
    tick();
    RST_X = 1'b1;
  endtask

  task automatic compare_model();
    logic [NC-1:0] eoh, eb;
    logic [127:0]  er;
    logic [65:0]   ebus;
    eoh  = 4'(1) << m_grant;
    eb   = 4'hF;
    if (m_phase == PH_RUN || m_phase == PH_WAIT) eb = (eb & ~eoh) | (s_busy ? eoh : 4'h0);
    er   = 128'(s_rdata) << (m_grant * DW);
    ebus = {32'(core_addr >> (m_grant * AW)), 32'(core_wdata >> (m_grant * DW)),
            1'((core_we >> m_grant) & 4'd1), 1'((core_le >> m_grant) & 4'd1)};
    check("rnd_grant", {grant, grant_oh}, {2'(m_grant), eoh});
    check("rnd_busy", core_busy, eb);
    check("rnd_rdata", core_rdata, er);
    check("rnd_sbus", {s_addr, s_wdata, s_we, s_le}, ebus);
  endtask

  task automatic wait_grant_change(input int budget, output int n);
    logic [1:0] g0;
    g0 = grant;
    n  = 0;
    while (grant == g0 && n < budget) begin
      tick();
      n++;
    end
  endtask

  typedef struct {
    logic          busy;
    logic [DW-1:0] rdata;
    logic [NC-1:0] we;
    logic [NC-1:0] le;
    logic [NC-1:0] exp_busy;
    logic          exp_we;
    logic          exp_le;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int n;
    int prev3;
    int wraps;
    int exp_g;

    vecs[0] = '{1'b0, 32'h0000_1234, 4'b0001, 4'b0000, 4'b1110, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 32'h0000_CAFE, 4'b1110, 4'b0001, 4'b1111, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 32'hFFFF_FFFF, 4'b0000, 4'b1110, 4'b1110, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 32'h0000_0000, 4'b1111, 4'b1111, 4'b1111, 1'b1, 1'b1};
    vecs[4] = '{1'b0, 32'h0000_5A5A, 4'b0010, 4'b0100, 4'b1110, 1'b0, 1'b0};

    RST_X = 1'b0; init_done = 1'b0; core_req = '0; core_bnd = '0;
    core_we = '0; core_le = '0; s_rdata = '0; s_busy = 1'b0;
    core_addr  = {32'hA3A3_0003, 32'hA2A2_0002, 32'hA1A1_0001, 32'hA0A0_0000};
    core_wdata = {32'hD3D3_0003, 32'hD2D2_0002, 32'hD1D1_0001, 32'hD0D0_0000};
    do_reset();

    // Reset state and output muxing with arbitration frozen on core 0.
    for (int i = 0; i < 5; i++) begin
      s_busy = vecs[i].busy; s_rdata = vecs[i].rdata;
      core_we = vecs[i].we;  core_le = vecs[i].le;
      #1;
      check("tbl_grant", {grant, grant_oh}, {2'd0, 4'b0001});
      check("tbl_busy", core_busy, vecs[i].exp_busy);
      check("tbl_we_le", {s_we, s_le}, {vecs[i].exp_we, vecs[i].exp_le});
      check("tbl_rdata", core_rdata, 128'(vecs[i].rdata));
      check("tbl_sbus", {s_addr, s_wdata}, {32'hA0A0_0000, 32'hD0D0_0000});
      tick();
    end

    // Rotation with every core at a boundary: 12 cycles to first switch, 13 per slice after.
    init_done = 1'b1; core_bnd = 4'hF; core_req = 4'hF; s_busy = 1'b0;
    do_reset();
    for (int s = 1; s <= 4; s++) begin
      wait_grant_change(40, n);
      check("rot_grant", grant, s % NC);
      check("rot_period", n, (s == 1) ? 12 : 13);
      check("rot_settle_busy", core_busy, 4'hF);
    end

    // Boundary withheld: owner keeps the bus in WAIT_BND, switch two cycles after it rises.
    core_bnd = 4'h0;
    do_reset();
    for (int i = 0; i < 36; i++) tick();
    check("bnd_hold_grant", grant, 2'd0);
    check("bnd_hold_busy", core_busy, 4'b1110);
    core_bnd = 4'b0001;
    tick();
    check("bnd_switch_busy", {grant, core_busy}, {2'd0, 4'hF});
    wait_grant_change(10, n);
    check("bnd_latency", {grant, 8'(n)}, {2'd1, 8'd1});

    // Downstream busy blocks the hand-over and stalls the owner throughout.
    core_bnd = 4'hF; s_busy = 1'b1;
    do_reset();
    for (int i = 0; i < 25; i++) tick();
    check("sbusy_grant", grant, 2'd0);
    check("sbusy_busy", core_busy, 4'hF);
    s_busy = 1'b0;
    wait_grant_change(10, n);
    check("sbusy_release", {grant, 8'(n)}, {2'd1, 8'd2});

    // Reset asserted while switching away from core 2.
    do_reset();
    wait_grant_change(40, n);
    wait_grant_change(40, n);
    check("rst_pre_grant", grant, 2'd2);
    for (int i = 0; i < 12; i++) tick();
    check("rst_in_switch", {grant, core_busy}, {2'd2, 4'hF});
    RST_X = 1'b0; s_busy = 1'b1;
    tick();
    check("rst_grant", {grant, grant_oh}, {2'd0, 4'b0001});
    check("rst_busy_hi", core_busy, 4'hF);
    s_busy = 1'b0;
    #1;
    check("rst_busy_lo", core_busy, 4'b1110);
    RST_X = 1'b1;

    // init_done low freezes the slice counter.
    init_done = 1'b0;
    do_reset();
    for (int i = 0; i < 30; i++) tick();
    check("freeze_grant", grant, 2'd0);
    init_done = 1'b1;
    wait_grant_change(40, n);
    check("freeze_resume", {grant, 8'(n)}, {2'd1, 8'd12});

`ifdef ARB_SKIP_IDLE_EN
    core_req = 4'b1001;
    do_reset();
    wait_grant_change(40, n);
    check("skip_to_3", {grant, 8'(n)}, {2'd3, 8'd12});
    core_req = 4'b0001;
    wait_grant_change(40, n);
    check("skip_to_0", grant, 2'd0);
    for (int i = 0; i < 12; i++) tick();
    check("skip_renew", {grant, core_busy}, {2'd0, 4'b1110});
`else
    core_req = 4'b0001;
    do_reset();
    wait_grant_change(40, n);
    check("strict_idle_slice", {grant, 8'(n)}, {2'd1, 8'd12});
`endif

    // Three-core instance must wrap 2 -> 0 and never present index 3.
    do_reset();
    prev3 = 0; wraps = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (int'(grant3) != prev3) begin
        exp_g = (prev3 == 2) ? 0 : prev3 + 1;
        check("n3_next", grant3, exp_g);
        if (prev3 == 2 && grant3 == 2'd0) wraps++;
        prev3 = int'(grant3);
      end
    end
    check("n3_wrapped", wraps > 0, 1'b1);

    // Randomized traffic against the reference model.
    core_req = 4'hF;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      RST_X      = ($urandom_range(0, 199) != 0);
      init_done  = ($urandom_range(0, 9) != 0);
      core_req   = 4'($urandom);
      core_bnd   = 4'($urandom | $urandom);
      s_busy     = ($urandom_range(0, 3) == 0);
      s_rdata    = $urandom;
      core_we    = 4'($urandom);
      core_le    = 4'($urandom);
      core_addr  = {$urandom, $urandom, $urandom, $urandom};
      core_wdata = {$urandom, $urandom, $urandom, $urandom};
      #1;
      compare_model();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
